// File: rtl/fp_pkg.sv
// Shared types, flag indices and IEEE-754 field helpers for the floating-point units.
// Helpers take the field widths as arguments so one package serves every format.
package fp_pkg;

    localparam int unsigned MaxW = 64;
    typedef logic [MaxW-1:0] word_t;

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StSpecial,
        StMul,
        StNorm,
        StRound,
        StDone
    } state_e;

    typedef enum logic {
        RndRne = 1'b0,
        RndRtz = 1'b1
    } rnd_mode_e;

    localparam int unsigned FlagInexact   = 0;
    localparam int unsigned FlagUnderflow = 1;
    localparam int unsigned FlagOverflow  = 2;
    localparam int unsigned FlagInvalid   = 3;

    function automatic word_t low_mask(input int unsigned w);
        word_t m;
        m = '0;
        for (int unsigned i = 0; i < MaxW; i++) begin
            if (i < w) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic word_t exp_field(input word_t x, input int unsigned ew,
                                        input int unsigned mw);
        return (x >> mw) & low_mask(ew);
    endfunction

    function automatic word_t frac_field(input word_t x, input int unsigned mw);
        return x & low_mask(mw);
    endfunction

    function automatic logic is_nan(input word_t x, input int unsigned ew, input int unsigned mw);
        return (exp_field(x, ew, mw) == low_mask(ew)) && (frac_field(x, mw) != '0);
    endfunction

    // Signalling NaNs have the fraction MSB clear.
    function automatic logic is_snan(input word_t x, input int unsigned ew, input int unsigned mw);
        return is_nan(x, ew, mw) && (((x >> (mw - 1)) & word_t'(1)) == '0);
    endfunction

    function automatic logic is_inf(input word_t x, input int unsigned ew, input int unsigned mw);
        return (exp_field(x, ew, mw) == low_mask(ew)) && (frac_field(x, mw) == '0);
    endfunction

    function automatic logic is_zero_or_sub(input word_t x, input int unsigned ew,
                                            input int unsigned mw);
        return exp_field(x, ew, mw) == '0;
    endfunction

    function automatic word_t qnan(input int unsigned ew, input int unsigned mw);
        return (low_mask(ew) << mw) | (word_t'(1) << (mw - 1));
    endfunction

    function automatic word_t max_finite(input int unsigned ew, input int unsigned mw);
        return ((low_mask(ew) - word_t'(1)) << mw) | low_mask(mw);
    endfunction

endpackage

// File: rtl/fp_mult_seq_mant_mul.sv
// Sequential shift-add significand multiplier: one multiplier bit per cycle, N cycles fixed.
// done is high during the final step; product is valid from the next cycle and held until start.
module mant_mul_seq #(
    parameter int unsigned N = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             done,
    output logic [2*N-1:0]   product
);

    localparam int unsigned CW = $clog2(N + 1);

    logic [2*N-1:0] mcand_q;
    logic [N-1:0]   mplier_q;
    logic [CW-1:0]  count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            product  <= '0;
        end else if (start) begin
            mcand_q  <= {{N{1'b0}}, a};
            mplier_q <= b;
            count_q  <= CW'(N);
            product  <= '0;
        end else if (count_q != '0) begin
            if (mplier_q[0]) begin
                product <= product + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q - CW'(1);
        end
    end

    assign done = (count_q == CW'(1));

endmodule

// File: rtl/fp_mult_seq.sv
// Multi-cycle floating-point multiplier with RNE/RTZ rounding, IEEE-style exception flags
// and flush-to-zero for subnormal inputs and outputs.
module fp_mult_seq
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   rnd_mode,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   busy,
    output logic                   ready,
    output logic [EXP_W+MAN_W:0]   y,
    output logic [3:0]             flags
);

    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned N    = MAN_W + 1;
    localparam int unsigned PW   = 2 * N;
    localparam int unsigned EW2  = EXP_W + 2;
    localparam int unsigned BIAS = 2 ** (EXP_W - 1) - 1;

    localparam word_t          QNAN_WORD   = qnan(EXP_W, MAN_W);
    localparam word_t          MAXF_WORD   = max_finite(EXP_W, MAN_W);
    localparam logic [W-2:0]   QNAN_MAG    = QNAN_WORD[W-2:0];
    localparam logic [W-2:0]   MAXF_MAG    = MAXF_WORD[W-2:0];
    localparam logic [W-2:0]   INF_MAG     = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [EW2-1:0] EXP_MAX     = EW2'(2 ** EXP_W - 1);
    localparam logic [PW-1:0]  STICKY_MASK = (PW'(1) << (MAN_W - 2)) - PW'(1);

    state_e          state;
    logic [W-1:0]    a_q, b_q;
    rnd_mode_e       rnd_q;
    logic            sign_q;
    // Two's-complement exponent with two guard bits; MSB set means negative.
    logic [EW2-1:0]  exp_q;
    logic [N-1:0]    sig_a_q, sig_b_q;
    logic [MAN_W-1:0] frac_q;
    logic            g_q, r_q, s_q;

    // Operand classification on the captured words.
    logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;

    assign a_nan  = is_nan(word_t'(a_q), EXP_W, MAN_W);
    assign b_nan  = is_nan(word_t'(b_q), EXP_W, MAN_W);
    assign a_snan = is_snan(word_t'(a_q), EXP_W, MAN_W);
    assign b_snan = is_snan(word_t'(b_q), EXP_W, MAN_W);
    assign a_inf  = is_inf(word_t'(a_q), EXP_W, MAN_W);
    assign b_inf  = is_inf(word_t'(b_q), EXP_W, MAN_W);
    assign a_zero = is_zero_or_sub(word_t'(a_q), EXP_W, MAN_W);
    assign b_zero = is_zero_or_sub(word_t'(b_q), EXP_W, MAN_W);

    logic         special_hit;
    logic [W-1:0] special_y;
    logic [3:0]   special_flags;

    always_comb begin
        special_hit   = 1'b1;
        special_y     = '0;
        special_flags = '0;
        if (a_nan || b_nan) begin
            special_y                  = {1'b0, QNAN_MAG};
            special_flags[FlagInvalid] = a_snan | b_snan;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            special_y                  = {1'b0, QNAN_MAG};
            special_flags[FlagInvalid] = 1'b1;
        end else if (a_inf || b_inf) begin
            special_y = {sign_q, INF_MAG};
        end else if (a_zero || b_zero) begin
            special_y = {sign_q, {(W-1){1'b0}}};
        end else begin
            special_hit = 1'b0;
        end
    end

    logic          mul_start, mul_done;
    logic [PW-1:0] prod;

    assign mul_start = (state == StSpecial) && !special_hit;

    mant_mul_seq #(
        .N (N)
    ) u_mant_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (sig_a_q),
        .b       (sig_b_q),
        .done    (mul_done),
        .product (prod)
    );

    // Product lies in [1,4); after normalisation the leading one sits at bit PW-2.
    logic [PW-1:0] prod_n;
    logic          shift_out;
    logic          unused_prod;

    assign prod_n      = prod[PW-1] ? (prod >> 1) : prod;
    assign shift_out   = prod[PW-1] & prod[0];
    assign unused_prod = ^prod_n[PW-1:PW-2];

    logic             round_inc, carry, uflow, oflow;
    logic [MAN_W-1:0] frac_r;
    logic [EW2-1:0]   exp_r;
    logic [W-1:0]     round_y;
    logic [3:0]       round_flags;

    always_comb begin
        round_inc       = (rnd_q == RndRne) & g_q & (r_q | s_q | frac_q[0]);
        {carry, frac_r} = {1'b0, frac_q} + {{MAN_W{1'b0}}, round_inc};
        exp_r           = exp_q + {{(EW2-1){1'b0}}, carry};
        uflow           = exp_q[EW2-1] | (exp_q == '0);
        oflow           = !exp_r[EW2-1] && (exp_r >= EXP_MAX);
        round_y         = {sign_q, exp_r[EXP_W-1:0], frac_r};
        round_flags     = '0;
        if (uflow) begin
            round_y                    = {sign_q, {(W-1){1'b0}}};
            round_flags[FlagUnderflow] = 1'b1;
            round_flags[FlagInexact]   = 1'b1;
        end else if (oflow) begin
            round_y                   = {sign_q, (rnd_q == RndRtz) ? MAXF_MAG : INF_MAG};
            round_flags[FlagOverflow] = 1'b1;
            round_flags[FlagInexact]  = 1'b1;
        end else begin
            round_flags[FlagInexact] = g_q | r_q | s_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            busy    <= 1'b0;
            ready   <= 1'b0;
            y       <= '0;
            flags   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rnd_q   <= RndRne;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            sig_a_q <= '0;
            sig_b_q <= '0;
            frac_q  <= '0;
            g_q     <= 1'b0;
            r_q     <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            ready <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        rnd_q <= rnd_mode_e'(rnd_mode);
                        busy  <= 1'b1;
                        state <= StUnpack;
                    end
                end
                StUnpack: begin
                    sign_q  <= a_q[W-1] ^ b_q[W-1];
                    exp_q   <= EW2'(a_q[W-2:MAN_W]) + EW2'(b_q[W-2:MAN_W]) - EW2'(BIAS);
                    sig_a_q <= {1'b1, a_q[MAN_W-1:0]};
                    sig_b_q <= {1'b1, b_q[MAN_W-1:0]};
                    state   <= StSpecial;
                end
                StSpecial: begin
                    if (special_hit) begin
                        y     <= special_y;
                        flags <= special_flags;
                        ready <= 1'b1;
                        state <= StDone;
                    end else begin
                        state <= StMul;
                    end
                end
                StMul: begin
                    if (mul_done) state <= StNorm;
                end
                StNorm: begin
                    frac_q <= prod_n[PW-3 -: MAN_W];
                    g_q    <= prod_n[MAN_W-1];
                    r_q    <= prod_n[MAN_W-2];
                    s_q    <= (|(prod_n & STICKY_MASK)) | shift_out;
                    exp_q  <= exp_q + EW2'(prod[PW-1]);
                    state  <= StRound;
                end
                StRound: begin
                    y     <= round_y;
                    flags <= round_flags;
                    ready <= 1'b1;
                    state <= StDone;
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mult_seq.sv
// Scoreboard bench for fp_mult_seq: directed vectors push expectations, a monitor checks on ready.
module tb_fp_mult_seq;

    logic        clk, rst_n, start, rnd_mode;
    logic [31:0] a, b, y;
    logic        busy, ready;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] y;
        logic [3:0]  f;
        int          t0;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    fp_mult_seq #(
        .EXP_W (8),
        .MAN_W (23)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rnd_mode (rnd_mode),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .ready    (ready),
        .y        (y),
        .flags    (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready=1 at cycle %0d, expected none", cyc);
            end else begin
                e = sb_q.pop_front();
                check({e.name, " y"}, y, e.y);
                check({e.name, " flags"}, {28'd0, flags}, {28'd0, e.f});
                check({e.name, " latency"}, 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb,
                          input logic rm, input logic [31:0] ey, input logic [3:0] ef,
                          input int lat, input bit poke);
        exp_t e;
        int   bcnt;
        bcnt     = 0;
        e.y      = ey;
        e.f      = ef;
        e.t0     = cyc;
        e.lat    = lat;
        e.name   = name;
        sb_q.push_back(e);
        a        = ta;
        b        = tb;
        rnd_mode = rm;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            // A start raised mid-operation must be ignored.
            if (poke && i == 5) begin
                start = 1'b1;
                a     = 32'h7F800000;
                b     = 32'h00000000;
            end else begin
                start = 1'b0;
            end
            if (busy) bcnt++;
            else break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({name, " busy_cycles"}, 32'(bcnt), 32'(lat));
        check({name, " pending"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rnd_mode = 1'b0;
        a        = '0;
        b        = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset busy",  32'(busy),  32'd0);
        check("reset ready", 32'(ready), 32'd0);
        check("reset y",     y,          32'd0);
        check("reset flags", 32'(flags), 32'd0);

        run_op("t1 1.5x2",      32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 29, 1'b0);
        run_op("t2 -3x0.5",     32'hC0400000, 32'h3F000000, 1'b0, 32'hBFC00000, 4'b0000, 29, 1'b0);
        run_op("t2 sticky",     32'h3F800001, 32'h3F800001, 1'b0, 32'h3F800002, 4'b0001, 29, 1'b0);
        run_op("t3 infx0",      32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000,  3, 1'b0);
        run_op("t3 -infx2",     32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 4'b0000,  3, 1'b0);
        run_op("t4 ovf rne",    32'h7F7FFFFF, 32'h40000000, 1'b0, 32'h7F800000, 4'b0101, 29, 1'b0);
        run_op("t4 ovf rtz",    32'h7F7FFFFF, 32'h40000000, 1'b1, 32'h7F7FFFFF, 4'b0101, 29, 1'b0);
        run_op("t5 uflow",      32'h00800000, 32'h3F000000, 1'b0, 32'h00000000, 4'b0011, 29, 1'b0);
        run_op("t5 daz",        32'h80000001, 32'h3F800000, 1'b0, 32'h80000000, 4'b0000,  3, 1'b0);
        run_op("snan",          32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000,  3, 1'b0);
        run_op("qnan",          32'hFFC00001, 32'h00000000, 1'b0, 32'h7FC00000, 4'b0000,  3, 1'b0);
        run_op("rne round up",  32'h3FC00001, 32'h3FC00000, 1'b0, 32'h40100001, 4'b0001, 29, 1'b0);
        run_op("rtz truncate",  32'h3FC00001, 32'h3FC00000, 1'b1, 32'h40100000, 4'b0001, 29, 1'b0);
        run_op("tie odd",       32'h3F800001, 32'h40400000, 1'b0, 32'h40400002, 4'b0001, 29, 1'b0);
        run_op("tie even",      32'h3F800003, 32'h40400000, 1'b0, 32'h40400004, 4'b0001, 29, 1'b0);

        // Abort an operation with reset in cycle 10; no result may appear.
        a        = 32'h3FC00000;
        b        = 32'h40000000;
        rnd_mode = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort busy",  32'(busy),  32'd0);
        check("abort ready", 32'(ready), 32'd0);
        check("abort y",     y,          32'd0);
        check("abort flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("abort busy after", 32'(busy), 32'd0);

        run_op("t6 reissue",    32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 29, 1'b1);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
